// File: rtl/reg_update_scheduler.sv
// ---------------------------------------------------------------------------
// reg_update_scheduler
//
// Arbitrates register writes from two requesters (0: SPI, 1: on-chip host)
// into a bank of five shadow registers, and copies modified shadows into the
// active registers that drive the PWM datapath only at a PWM period boundary,
// so the PWM never sees a half-updated configuration.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   req0_valid/addr/data, req1_valid/addr/data
//                   write requests; held stable until the matching ready
//   req0_ready, req1_ready
//                   registered one-cycle accept strobes, never both high
//   period_end      one-cycle pulse at the PWM period boundary
//   reg_out0..4     active register values
//   err_pulse       one-cycle flag for a dropped out-of-range write
//   err_count       saturating count of dropped writes
//   update_pending  high while any shadow holds a value not yet made active
//
// Timing: a request sampled in IDLE gives ready on the next cycle (ACCEPT),
// err_pulse on the cycle after (COMMIT), and the shadow/dirty update on the
// edge that leaves COMMIT. One write per three cycles at most.
//
// MAX_ADDR selects the highest legal address; the register bank itself has
// five entries, so MAX_ADDR is expected to be at most 4.
// ---------------------------------------------------------------------------
module reg_update_scheduler #(
    parameter int MAX_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic       period_end,
    output logic [7:0] reg_out0,
    output logic [7:0] reg_out1,
    output logic [7:0] reg_out2,
    output logic [7:0] reg_out3,
    output logic [7:0] reg_out4,
    output logic       err_pulse,
    output logic [7:0] err_count,
    output logic       update_pending
);

    localparam int         NUM_REGS = 5;
    localparam logic [6:0] MAX_A    = 7'(MAX_ADDR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    // last_gnt holds the id of the most recent grantee; resetting it to 1
    // makes requester 0 win the first contended arbitration.
    logic                   last_gnt;
    logic                   gnt_sel;
    logic [6:0]             lat_addr;
    logic [7:0]             lat_data;
    logic                   addr_ok;
    logic                   commit_wr;

    logic [7:0]             shadow [NUM_REGS];
    logic [7:0]             active [NUM_REGS];
    logic [NUM_REGS-1:0]    dirty;
    logic [NUM_REGS-1:0]    dirty_nxt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Only IDLE looks at the requests; ACCEPT and COMMIT
    // always advance, which fixes the three-cycle cadence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0_valid || req1_valid) state_nxt = ACCEPT;
            ACCEPT:  state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant choice, address legality and the next dirty vector.
    // Dirty bits are cleared by period_end first and then the committing
    // write re-sets its own bit, so a write landing on the same edge as
    // period_end stays pending for the following period.
    always_comb begin
        gnt_sel   = req1_valid && (!req0_valid || !last_gnt);
        addr_ok   = (lat_addr <= MAX_A);
        commit_wr = (state == COMMIT) && addr_ok;
        dirty_nxt = dirty;
        if (period_end) begin
            dirty_nxt = '0;
        end
        if (commit_wr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (lat_addr == 7'(i)) begin
                    dirty_nxt[i] = 1'b1;
                end
            end
        end
    end

    // Request capture and ready strobes. The addr/data are latched when the
    // grant is made, so a requester that drops valid early is still
    // committed with what was captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt   <= 1'b1;
            lat_addr   <= '0;
            lat_data   <= '0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            if (state == IDLE && (req0_valid || req1_valid)) begin
                last_gnt   <= gnt_sel;
                lat_addr   <= gnt_sel ? req1_addr : req0_addr;
                lat_data   <= gnt_sel ? req1_data : req0_data;
                req0_ready <= !gnt_sel;
                req1_ready <= gnt_sel;
            end
        end
    end

    // Shadow/active bank, dirty tracking and error reporting.
    // The active copy reads the shadow value from before this edge, so a
    // write committing on a period_end edge is not made active yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            dirty          <= '0;
            update_pending <= 1'b0;
            err_pulse      <= 1'b0;
            err_count      <= '0;
        end else begin
            dirty          <= dirty_nxt;
            update_pending <= |dirty_nxt;
            err_pulse      <= (state == ACCEPT) && !addr_ok;
            if (state == COMMIT && !addr_ok && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (period_end && dirty[i]) begin
                    active[i] <= shadow[i];
                end
                if (commit_wr && lat_addr == 7'(i)) begin
                    shadow[i] <= lat_data;
                end
            end
        end
    end

    assign reg_out0 = active[0];
    assign reg_out1 = active[1];
    assign reg_out2 = active[2];
    assign reg_out3 = active[3];
    assign reg_out4 = active[4];

endmodule

// File: tb/tb_reg_update_scheduler.sv
// ---------------------------------------------------------------------------
// tb_reg_update_scheduler
//
// Directed bench for reg_update_scheduler. Expected grants (requester id and
// cycle) and expected error pulses (cycle) are queued when a request is
// driven and popped when the DUT shows ready / err_pulse. Register values
// are checked against constants chosen by each step.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_reg_update_scheduler;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic [6:0] req0_addr;
    logic [7:0] req0_data;
    logic       req1_valid;
    logic [6:0] req1_addr;
    logic [7:0] req1_data;
    logic       req0_ready;
    logic       req1_ready;
    logic       period_end;
    logic [7:0] reg_out0;
    logic [7:0] reg_out1;
    logic [7:0] reg_out2;
    logic [7:0] reg_out3;
    logic [7:0] reg_out4;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       update_pending;

    typedef struct {
        int id;
        int cyc;
    } grant_t;

    grant_t gq[$];
    int     eq[$];
    int     cyc;
    int     grants_seen;
    int     checks;
    int     errors;

    reg_update_scheduler #(.MAX_ADDR(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_addr      (req0_addr),
        .req0_data      (req0_data),
        .req1_valid     (req1_valid),
        .req1_addr      (req1_addr),
        .req1_data      (req1_data),
        .req0_ready     (req0_ready),
        .req1_ready     (req1_ready),
        .period_end     (period_end),
        .reg_out0       (reg_out0),
        .reg_out1       (reg_out1),
        .reg_out2       (reg_out2),
        .reg_out3       (reg_out3),
        .reg_out4       (reg_out4),
        .err_pulse      (err_pulse),
        .err_count      (err_count),
        .update_pending (update_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: advance to the next rising edge, then inspect the outputs
    // on the falling edge and retire any queued grant / error expectation.
    task automatic tick();
        grant_t g;
        int     e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (req0_ready || req1_ready) begin
            grants_seen++;
            checkOutput("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
            checkOutput("grant_expected", 32'(gq.size() != 0), 32'd1);
            if (gq.size() != 0) begin
                g = gq.pop_front();
                checkOutput("grant_id", req1_ready ? 32'd1 : 32'd0, 32'(g.id));
                checkOutput("grant_cycle", 32'(cyc), 32'(g.cyc));
            end
        end
        if (err_pulse) begin
            checkOutput("err_expected", 32'(eq.size() != 0), 32'd1);
            if (eq.size() != 0) begin
                e = eq.pop_front();
                checkOutput("err_cycle", 32'(cyc), 32'(e));
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_reg_out0"}, 32'(reg_out0), 32'd0);
        checkOutput({tag, "_reg_out1"}, 32'(reg_out1), 32'd0);
        checkOutput({tag, "_reg_out2"}, 32'(reg_out2), 32'd0);
        checkOutput({tag, "_reg_out3"}, 32'(reg_out3), 32'd0);
        checkOutput({tag, "_reg_out4"}, 32'(reg_out4), 32'd0);
        checkOutput({tag, "_err_count"}, 32'(err_count), 32'd0);
        checkOutput({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        checkOutput({tag, "_pending"}, 32'(update_pending), 32'd0);
        checkOutput({tag, "_ready"}, 32'({req1_ready, req0_ready}), 32'd0);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulsePeriodEnd();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    // Single write from one requester while the scheduler is idle. Returns
    // on the cycle after COMMIT, when the scheduler is back in IDLE.
    // pe_on_commit raises period_end so that it is sampled on the COMMIT edge.
    task automatic applyStimulus(input int id, input logic [6:0] addr, input logic [7:0] data,
                                 input bit expect_err, input bit pe_on_commit);
        int k;
        int gs;
        bit got;
        if (id == 0) begin
            req0_valid = 1'b1; req0_addr = addr; req0_data = data;
        end else begin
            req1_valid = 1'b1; req1_addr = addr; req1_data = data;
        end
        k = cyc;
        gq.push_back('{id: id, cyc: k + 1});
        if (expect_err) eq.push_back(k + 2);
        gs  = grants_seen;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (grants_seen != gs) got = 1'b1;
        end
        checkOutput("ready_within_bound", 32'(got), 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        period_end = pe_on_commit;
        tick();
        period_end = 1'b0;
    endtask

    initial begin
        int k;
        int gs;
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        period_end = 1'b0;
        cyc = 0; grants_seen = 0; checks = 0; errors = 0;

        // Reset state.
        resetDut();
        checkResetState("reset");

        // Contention: both requesters valid continuously, grants alternate
        // starting with requester 0, three cycles apart.
        req0_valid = 1'b1; req0_addr = 7'd0; req0_data = 8'h31;
        req1_valid = 1'b1; req1_addr = 7'd1; req1_data = 8'h42;
        k = cyc;
        gq.push_back('{id: 0, cyc: k + 1});
        gq.push_back('{id: 1, cyc: k + 4});
        gq.push_back('{id: 0, cyc: k + 7});
        gq.push_back('{id: 1, cyc: k + 10});
        gs = grants_seen;
        for (int i = 0; i < 20 && (grants_seen - gs) < 4; i++) tick();
        checkOutput("contention_grants", 32'(grants_seen - gs), 32'd4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(); tick(); tick();
        checkOutput("contention_pending", 32'(update_pending), 32'd1);
        pulsePeriodEnd();
        checkOutput("contention_reg_out0", 32'(reg_out0), 32'h31);
        checkOutput("contention_reg_out1", 32'(reg_out1), 32'h42);
        checkOutput("contention_pending_clr", 32'(update_pending), 32'd0);

        // Single write addr 2 = 0xA5: pending three cycles after request,
        // active only after period_end.
        resetDut();
        applyStimulus(0, 7'd2, 8'hA5, 1'b0, 1'b0);
        checkOutput("single_pending", 32'(update_pending), 32'd1);
        checkOutput("single_reg_out2_pre", 32'(reg_out2), 32'd0);
        pulsePeriodEnd();
        checkOutput("single_reg_out2", 32'(reg_out2), 32'hA5);
        checkOutput("single_pending_clr", 32'(update_pending), 32'd0);

        // Out-of-range write from requester 1 is dropped and counted.
        applyStimulus(1, 7'd5, 8'hFF, 1'b1, 1'b0);
        checkOutput("oor_err_count", 32'(err_count), 32'd1);
        checkOutput("oor_pending", 32'(update_pending), 32'd0);
        pulsePeriodEnd();
        checkOutput("oor_reg_out2", 32'(reg_out2), 32'hA5);
        checkOutput("oor_reg_out4", 32'(reg_out4), 32'd0);
        checkOutput("oor_reg_out0", 32'(reg_out0), 32'd0);
        for (int n = 2; n <= 300; n++) begin
            applyStimulus(1, (n % 2 == 0) ? 7'd127 : 7'd5, 8'hFF, 1'b1, 1'b0);
            if (n == 254) checkOutput("oor_count_254", 32'(err_count), 32'd254);
            if (n == 255) checkOutput("oor_count_255", 32'(err_count), 32'd255);
            if (n == 256) checkOutput("oor_count_sat", 32'(err_count), 32'd255);
        end
        checkOutput("oor_count_300", 32'(err_count), 32'd255);
        checkOutput("oor_pending_end", 32'(update_pending), 32'd0);

        // Coalescing: two writes to addr 3 before the boundary, last wins.
        applyStimulus(0, 7'd3, 8'h11, 1'b0, 1'b0);
        applyStimulus(1, 7'd3, 8'h22, 1'b0, 1'b0);
        checkOutput("coalesce_reg_out3_pre", 32'(reg_out3), 32'd0);
        pulsePeriodEnd();
        checkOutput("coalesce_reg_out3", 32'(reg_out3), 32'h22);

        // Collision: second write to addr 4 commits on the period_end edge;
        // the boundary applies the earlier value and the new one stays pending.
        applyStimulus(0, 7'd4, 8'h10, 1'b0, 1'b0);
        applyStimulus(1, 7'd4, 8'h20, 1'b0, 1'b1);
        checkOutput("collide_reg_out4", 32'(reg_out4), 32'h10);
        checkOutput("collide_pending", 32'(update_pending), 32'd1);
        pulsePeriodEnd();
        checkOutput("collide_reg_out4_next", 32'(reg_out4), 32'h20);
        checkOutput("collide_pending_clr", 32'(update_pending), 32'd0);

        // Reset during ACCEPT: everything clears at once and the captured
        // write is never committed.
        req0_valid = 1'b1; req0_addr = 7'd2; req0_data = 8'h77;
        k = cyc;
        gq.push_back('{id: 0, cyc: k + 1});
        gs = grants_seen;
        tick();
        checkOutput("midreset_ready_seen", 32'(grants_seen - gs), 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        req0_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        applyStimulus(1, 7'd1, 8'h5A, 1'b0, 1'b0);
        checkOutput("postreset_err_count", 32'(err_count), 32'd0);
        pulsePeriodEnd();
        checkOutput("postreset_reg_out1", 32'(reg_out1), 32'h5A);
        checkOutput("postreset_reg_out2", 32'(reg_out2), 32'd0);
        checkOutput("postreset_reg_out4", 32'(reg_out4), 32'd0);

        // Nothing left outstanding.
        tick(); tick(); tick();
        checkOutput("grant_q_drained", 32'(gq.size()), 32'd0);
        checkOutput("err_q_drained", 32'(eq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule

// File: doc/reg_update_scheduler.md
REG_UPDATE_SCHEDULER -- requirements
Module: reg_update_scheduler

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 4, highest legal register address.
REQ-002 SHALL have clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req0_valid / req1_valid  input  1 each  write request from requester 0 (SPI) / requester 1 (on-chip host).
REQ-005 SHALL have req0_addr / req1_addr  input  7 each  target register address.
REQ-006 SHALL have req0_data / req1_data  input  8 each  write data.
REQ-007 SHALL have req0_ready / req1_ready  output  1 each  registered accept strobe.
REQ-008 SHALL have period_end  input  1  single-cycle pulse at PWM period boundary.
REQ-009 SHALL have reg_out0..reg_out4  output  8 each  active register values driving PWM datapath.
REQ-010 SHALL have err_pulse  output  1  one-cycle flag for dropped out-of-range write.
REQ-011 SHALL have err_count  output  8  saturating count of dropped writes.
REQ-012 SHALL have update_pending  output  1  high while any shadow register differs-by-write from active.

Function
REQ-013 SHALL implement FSM states IDLE, ACCEPT, COMMIT.
REQ-014 IDLE: if any reqN_valid, SHALL select grantee, latch its addr/data, go ACCEPT; else stay IDLE.
REQ-015 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; after reset requester 0 has priority.
REQ-016 ACCEPT: SHALL drive reqN_ready high for exactly one cycle for grantee only; go COMMIT unconditionally.
REQ-017 Requesters SHALL hold valid/addr/data stable until ready; transfer occurs on the valid&ready cycle.
REQ-018 COMMIT: addr <= MAX_ADDR -> write data to shadow[addr], set dirty[addr]; else drop, pulse err_pulse, increment err_count; then IDLE.
REQ-019 Latency SHALL be: valid sampled cycle N, ready cycle N+1, shadow write/err_pulse cycle N+2; max throughput one write per 3 cycles.
REQ-020 err_count SHALL saturate at 255, never wrap.
REQ-021 On period_end, every register with dirty set SHALL copy shadow to reg_outN and clear dirty; non-dirty registers unchanged.
REQ-022 period_end in same cycle as COMMIT write: transfer uses pre-write shadow; new write's dirty bit stays set, applied at next period_end.
REQ-023 Repeated writes to one address before period_end SHALL coalesce; only last value becomes active.
REQ-024 update_pending SHALL equal OR of dirty bits (registered).
REQ-025 Requester dropping valid before ready SHALL still be committed with latched addr/data (protocol violation, defined outcome).
REQ-026 Both ready outputs SHALL never be high in the same cycle.

Reset
REQ-027 rst_n low SHALL asynchronously force FSM IDLE, all ready low, shadow and reg_out0..4 to 0x00, dirty to 0, err_pulse 0, err_count 0, round-robin pointer to favour requester 0.
REQ-028 Reset mid-ACCEPT or mid-COMMIT SHALL abort the write with no shadow or counter update.
REQ-029 After rst_n deassertion, first request SHALL be evaluated on the first rising clk edge.

Verification
REQ-030 Single write: req0 addr 2 data 0xA5, then period_end -> req0_ready at N+1, update_pending at N+3, reg_out2=0xA5 after period_end, pending 0.
REQ-031 Contention: both valid continuously, addrs 0/1 -> grants alternate 0,1,0,1; ready never concurrent; each grant 3 cycles apart.
REQ-032 Out-of-range: req1 addr 5 data 0xFF -> err_pulse one cycle, err_count 1, no reg_out/dirty change; 300 such writes -> err_count 255.
REQ-033 Coalesce/collision: write addr 4 0x10, then 0x20 with COMMIT coinciding with period_end -> reg_out4=0x10, pending 1; next period_end -> 0x20.
REQ-034 Reset mid-operation: assert rst_n low during ACCEPT -> all outputs 0 immediately, no write after release, next req1-only request granted normally.
